// File: rtl/axird_arb_if.sv
// AXI4 read-address and read-data channels between the arbiter (master)
// and the memory-side interconnect (slave).
interface axird_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;

  modport master (
    output arvalid, araddr, arlen, rready,
    input  arready, rvalid, rdata, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, rready,
    output arready, rvalid, rdata, rlast
  );
endinterface

// File: rtl/axird_arb.sv
// Two-requester AXI read engine: arbitrates jobs, splits each into
// 4 KB-safe bursts and streams returned beats into the requester's buffer.
//
// state  | meaning
// S_IDLE | no job in service
// S_ARB  | pick a pending requester, latch its job
// S_ADDR | AR burst presented, waiting for arready
// S_DATA | accepting R beats of the outstanding burst
// S_FIN  | done pulse, busy cleared, round-robin update
module axird_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BURST  = 16
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_req0_start,
  input  logic [ADDR_WIDTH-1:0] I_req0_addr,
  input  logic [15:0]           I_req0_len,
  output logic                  O_req0_busy,
  output logic                  O_req0_done,
  input  logic                  I_req1_start,
  input  logic [ADDR_WIDTH-1:0] I_req1_addr,
  input  logic [15:0]           I_req1_len,
  output logic                  O_req1_busy,
  output logic                  O_req1_done,
  axird_arb_if.master           maxi,
  output logic                  O_wr0,
  output logic                  O_wr1,
  output logic [15:0]           O_waddr,
  output logic [DATA_WIDTH-1:0] O_wdata,
  output logic                  O_err
);
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LOG_BYTES = $clog2(BYTES);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ADDR, S_DATA, S_FIN} state_t;
  state_t state_q, state_nxt;

  logic [1:0]            start, start_acc, busy_q, busy_o, done_o;
  logic [ADDR_WIDTH-1:0] req_addr [2];
  logic [15:0]           req_len [2];
  logic [ADDR_WIDTH-1:0] job_addr_q [2];
  logic [15:0]           job_len_q [2];
  logic                  grant_q, grant_nxt, rr_q, contend_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_nxt, sel_addr, ld_addr;
  logic [15:0]           remain_q, rem_after, sel_len, ld_len, widx_q;
  logic [8:0]            burst_q, bcnt_q, ld_beats;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic                  err_q, beat, last_beat, fin;

  // Burst size limited by remaining beats, MAX_BURST and the next 4 KB page.
  function automatic logic [8:0] calc_beats(input logic [11:0] off, input logic [15:0] rem);
    logic [12:0] room;
    logic [12:0] b4k;
    logic [16:0] b;
    room = 13'd4096 - {1'b0, off};
    b4k  = (room + 13'(BYTES - 1)) >> LOG_BYTES;
    b    = {1'b0, rem};
    if (b > 17'(MAX_BURST)) b = 17'(MAX_BURST);
    if (b > {4'd0, b4k}) b = {4'd0, b4k};
    return b[8:0];
  endfunction

  assign start       = {I_req1_start, I_req0_start};
  assign req_addr[0] = I_req0_addr;
  assign req_addr[1] = I_req1_addr;
  assign req_len[0]  = I_req0_len;
  assign req_len[1]  = I_req1_len;

  assign fin       = (state_q == S_FIN);
  assign done_o    = {fin & grant_q, fin & ~grant_q};
  assign busy_o    = busy_q & ~done_o;
  assign start_acc = start & ~busy_o;

  assign beat         = (state_q == S_DATA) & I_rst & maxi.rvalid;
  assign last_beat    = beat & ((bcnt_q + 9'd1) == burst_q);
  assign rem_after    = remain_q - 16'(burst_q);
  assign cur_addr_nxt = cur_addr_q + (ADDR_WIDTH'(burst_q) << LOG_BYTES);

  always_comb begin
    grant_nxt = grant_q;
    if (state_q == S_ARB) begin
      if (&busy_q)        grant_nxt = rr_q;
      else if (busy_q[1]) grant_nxt = 1'b1;
      else                grant_nxt = 1'b0;
    end
  end

  assign sel_addr = job_addr_q[grant_nxt];
  assign sel_len  = job_len_q[grant_nxt];

  always_comb begin
    state_nxt = state_q;
    ld_addr   = sel_addr;
    ld_len    = sel_len;
    case (state_q)
      S_IDLE: if ((|busy_q) || (|start_acc)) state_nxt = S_ARB;
      S_ARB: begin
        if (|busy_q) state_nxt = (sel_len == 16'd0) ? S_FIN : S_ADDR;
        else         state_nxt = S_IDLE;
      end
      S_ADDR: if (maxi.arready) state_nxt = S_DATA;
      S_DATA: begin
        ld_addr = cur_addr_nxt;
        ld_len  = rem_after;
        if (last_beat) state_nxt = (rem_after == 16'd0) ? S_FIN : S_ADDR;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ld_beats = calc_beats(ld_addr[11:0], ld_len);

  always_ff @(posedge I_clk) begin
    if (!I_rst) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      busy_q     <= '0;
      job_addr_q <= '{default: '0};
      job_len_q  <= '{default: '0};
      grant_q    <= 1'b0;
      rr_q       <= 1'b0;
      contend_q  <= 1'b0;
      cur_addr_q <= '0;
      remain_q   <= '0;
      widx_q     <= '0;
      burst_q    <= '0;
      bcnt_q     <= '0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (start_acc[n]) begin
          busy_q[n]     <= 1'b1;
          job_addr_q[n] <= req_addr[n];
          job_len_q[n]  <= req_len[n];
        end else if (done_o[n]) begin
          busy_q[n] <= 1'b0;
        end
      end

      if (state_q == S_ARB && state_nxt != S_IDLE) begin
        grant_q    <= grant_nxt;
        contend_q  <= &busy_q;
        cur_addr_q <= sel_addr;
        remain_q   <= sel_len;
        widx_q     <= '0;
      end

      // An early rlast is only flagged; the beat count alone closes the burst.
      if (beat) begin
        widx_q <= widx_q + 16'd1;
        bcnt_q <= bcnt_q + 9'd1;
        if (last_beat != maxi.rlast) err_q <= 1'b1;
        if (last_beat) begin
          cur_addr_q <= cur_addr_nxt;
          remain_q   <= rem_after;
        end
      end

      if (state_nxt == S_ADDR && state_q != S_ADDR) begin
        arvalid_q <= 1'b1;
        araddr_q  <= ld_addr;
        arlen_q   <= 8'(ld_beats - 9'd1);
        burst_q   <= ld_beats;
        bcnt_q    <= '0;
      end else if (state_q == S_ADDR && maxi.arready) begin
        arvalid_q <= 1'b0;
      end

      // The pointer only moves when a real contention was resolved.
      if (fin && contend_q) rr_q <= ~grant_q;
    end
  end

  assign maxi.arvalid = arvalid_q & I_rst;
  assign maxi.araddr  = araddr_q;
  assign maxi.arlen   = arlen_q;
  assign maxi.rready  = (state_q == S_DATA) & I_rst;

  assign O_wr0       = beat & ~grant_q;
  assign O_wr1       = beat & grant_q;
  assign O_waddr     = widx_q;
  assign O_wdata     = maxi.rdata;
  assign O_err       = err_q;
  assign O_req0_busy = busy_o[0];
  assign O_req1_busy = busy_o[1];
  assign O_req0_done = done_o[0];
  assign O_req1_done = done_o[1];
endmodule
